// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: the word is cut into STAGES segments,
// each a BLOCK-grouped lookahead adder, with the segment carry registered between stages.
module pipelined_cla_adder #(
   parameter int WIDTH  = 16,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c0,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             co,
   output logic             ovf,
   output logic             p,
   output logic             g
);
   localparam int SEG  = WIDTH / STAGES;
   localparam int NBLK = SEG / BLOCK;

   if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*BLOCK");
   end

   typedef struct packed {
      logic [SEG-1:0] sum;
      logic [SEG-1:0] cv;
      logic           co;
      logic           p;
      logic           g;
   } seg_t;

   // Two-level lookahead: cr[i] is the sum-of-products of generate/propagate terms,
   // so no carry ripples through the bits of a group.
   function automatic logic [BLOCK:0] block_carries(input logic [BLOCK-1:0] gv,
                                                    input logic [BLOCK-1:0] pv,
                                                    input logic             ci);
      logic [BLOCK:0] cr;
      logic           t;
      for (int i = 0; i <= BLOCK; i++) begin
         cr[i] = ci;
         for (int m = 0; m < i; m++) cr[i] = cr[i] & pv[m];
         for (int m = 0; m < i; m++) begin
            t = gv[m];
            for (int n = m + 1; n < i; n++) t = t & pv[n];
            cr[i] = cr[i] | t;
         end
      end
      return cr;
   endfunction

   function automatic seg_t seg_add(input logic [SEG-1:0] x,
                                    input logic [SEG-1:0] y,
                                    input logic           ci);
      seg_t           r;
      logic [SEG-1:0] pb;
      logic [SEG-1:0] gb;
      logic [NBLK:0]  bc;
      logic [BLOCK:0] lc;
      logic           bp;
      logic           bg;
      logic           gs;
      pb    = x ^ y;
      gb    = x & y;
      bc[0] = ci;
      gs    = 1'b0;
      r.cv  = '0;
      for (int j = 0; j < NBLK; j++) begin
         lc = block_carries(gb[j*BLOCK +: BLOCK], pb[j*BLOCK +: BLOCK], bc[j]);
         r.cv[j*BLOCK +: BLOCK] = lc[BLOCK-1:0];
         lc = block_carries(gb[j*BLOCK +: BLOCK], pb[j*BLOCK +: BLOCK], 1'b0);
         bg = lc[BLOCK];
         bp = &pb[j*BLOCK +: BLOCK];
         bc[j+1] = bg | (bp & bc[j]);
         gs      = bg | (bp & gs);
      end
      r.sum = pb ^ r.cv;
      r.co  = bc[NBLK];
      r.p   = &pb;
      r.g   = gs;
      return r;
   endfunction

   logic             en;
   logic [WIDTH-1:0] beff;
   logic             cin;

   // One global enable: the whole pipe, bubbles included, moves or holds together.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign beff     = sub ? ~b : b;
   assign cin      = sub ? 1'b1 : c0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int RIN = WIDTH - k * SEG;

      logic [RIN-1:0]       a_in;
      logic [RIN-1:0]       b_in;
      logic                 ci;
      logic                 pw_in;
      logic                 gw_in;
      logic                 vld_in;
      seg_t                 res;
      logic [(k+1)*SEG-1:0] s_nx;
      logic [(k+1)*SEG-1:0] c_nx;
      logic [(k+1)*SEG-1:0] s_p;
      logic [(k+1)*SEG-1:0] c_p;
      logic                 cy_p;
      logic                 pw_p;
      logic                 gw_p;
      logic                 vld_p;

      if (k == 0) begin : g_head
         assign a_in   = a;
         assign b_in   = beff;
         assign ci     = cin;
         assign pw_in  = 1'b1;
         assign gw_in  = 1'b0;
         assign vld_in = in_valid;
         assign s_nx   = res.sum;
         assign c_nx   = res.cv;
      end else begin : g_body
         assign a_in   = g_stage[k-1].g_fwd.a_p;
         assign b_in   = g_stage[k-1].g_fwd.b_p;
         assign ci     = g_stage[k-1].cy_p;
         assign pw_in  = g_stage[k-1].pw_p;
         assign gw_in  = g_stage[k-1].gw_p;
         assign vld_in = g_stage[k-1].vld_p;
         assign s_nx   = {res.sum, g_stage[k-1].s_p};
         assign c_nx   = {res.cv, g_stage[k-1].c_p};
      end

      assign res = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], ci);

      // Stage k boundary: finished low segments accumulate, word P/G fold in this segment.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p <= 1'b0;
            s_p   <= '0;
            c_p   <= '0;
            cy_p  <= 1'b0;
            pw_p  <= 1'b0;
            gw_p  <= 1'b0;
         end else if (en) begin
            vld_p <= vld_in;
            s_p   <= s_nx;
            c_p   <= c_nx;
            cy_p  <= res.co;
            pw_p  <= pw_in & res.p;
            gw_p  <= res.g | (res.p & gw_in);
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [RIN-SEG-1:0] a_p;
         logic [RIN-SEG-1:0] b_p;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_p <= '0;
               b_p <= '0;
            end else if (en) begin
               a_p <= a_in[RIN-1:SEG];
               b_p <= b_in[RIN-1:SEG];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_p;
   assign s         = g_stage[STAGES-1].s_p;
   assign c         = g_stage[STAGES-1].c_p;
   assign co        = g_stage[STAGES-1].cy_p;
   assign p         = g_stage[STAGES-1].pw_p;
   assign g         = g_stage[STAGES-1].gw_p;
   assign ovf       = c[WIDTH-1] ^ co;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner beats, a stalled stream, reset
// mid-stream and a long random valid/ready run scored against an arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
   localparam int WIDTH  = 16;
   localparam int BLOCK  = 4;
   localparam int STAGES = 2;

   localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] NEG2   = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] MSB    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};

   typedef logic [WIDTH:0] val_t;
   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic [WIDTH-1:0] c;
      logic             co;
      logic             ovf;
      logic             p;
      logic             g;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c0;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] c;
   logic             co;
   logic             ovf;
   logic             p;
   logic             g;

   int               n_cmp = 0;
   int               n_bad = 0;
   res_t             q[$];
   logic             held = 1'b0;
   logic [WIDTH-1:0] held_s = '0;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c0(c0), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .c(c), .co(co), .ovf(ovf), .p(p), .g(g)
   );

   task automatic chk(input string tag, input val_t obs, input val_t exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide addition; carries into each bit recovered as a^b^sum.
   function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic c0v, input logic subv);
      res_t             r;
      logic [WIDTH-1:0] be;
      logic             ci;
      logic [WIDTH:0]   full;
      logic [WIDTH:0]   gen;
      be    = subv ? ~bv : bv;
      ci    = subv ? 1'b1 : c0v;
      full  = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
      gen   = {1'b0, av} + {1'b0, be};
      r.s   = full[WIDTH-1:0];
      r.co  = full[WIDTH];
      r.c   = av ^ be ^ r.s;
      r.ovf = (av[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
      r.p   = &(av ^ be);
      r.g   = gen[WIDTH];
      return r;
   endfunction

   task automatic rand_operands();
      logic [63:0] r1;
      logic [63:0] r2;
      r1  = {$urandom(), $urandom()};
      r2  = {$urandom(), $urandom()};
      a   = r1[WIDTH-1:0];
      b   = r2[WIDTH-1:0];
      c0  = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
         0: begin a = ONES; b = WIDTH'(1); c0 = 1'b0; sub = 1'b0; end
         1: begin b = ~a; sub = 1'b0; end
         2: begin b = a; sub = 1'b1; end
         default: ;
      endcase
   endtask

   // One cycle with inputs already driven: score outputs, record any accepted beat.
   task automatic step(output logic acc);
      res_t e;
      #1;
      if (held) begin
         chk("hold_valid", val_t'(out_valid), val_t'(1));
         chk("hold_s", val_t'(s), val_t'(held_s));
      end
      chk("in_ready", val_t'(in_ready), val_t'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
         chk("q_has_beat", val_t'(q.size() > 0), val_t'(1));
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("s", val_t'(s), val_t'(e.s));
            chk("c", val_t'(c), val_t'(e.c));
            chk("co", val_t'(co), val_t'(e.co));
            chk("ovf", val_t'(ovf), val_t'(e.ovf));
            chk("p", val_t'(p), val_t'(e.p));
            chk("g", val_t'(g), val_t'(e.g));
         end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a, b, c0, sub));
      held   = out_valid && !out_ready;
      held_s = s;
      @(negedge clk);
   endtask

   task automatic one_beat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic c0v, input logic subv, output res_t got);
      int k;
      a = av; b = bv; c0 = c0v; sub = subv;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 chk("idle_ready", val_t'(in_ready), val_t'(1));
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      for (int n = 1; n <= STAGES + 3 && k == 0; n++) begin
         if (n > 1) @(negedge clk);
         #1;
         if (out_valid) k = n;
      end
      chk("latency", val_t'(k), val_t'(STAGES));
      got.s = s; got.c = c; got.co = co; got.ovf = ovf; got.p = p; got.g = g;
      @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      logic acc;
      int   sent;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c0 = 1'b0; sub = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid", val_t'(out_valid), val_t'(0));
      chk("rst_s", val_t'(s), val_t'(0));
      chk("rst_c", val_t'(c), val_t'(0));
      chk("rst_co", val_t'(co), val_t'(0));
      chk("rst_ovf", val_t'(ovf), val_t'(0));
      chk("rst_pg", val_t'({p, g}), val_t'(0));
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_ready", val_t'(in_ready), val_t'(1));
      @(negedge clk);

      one_beat(WIDTH'(8), WIDTH'(4), 1'b0, 1'b0, r);
      chk("t2_s", val_t'(r.s), val_t'(12));
      chk("t2_co", val_t'(r.co), val_t'(0));
      chk("t2_ovf", val_t'(r.ovf), val_t'(0));
      chk("t2_p", val_t'(r.p), val_t'(0));
      chk("t2_g", val_t'(r.g), val_t'(0));

      one_beat(ONES, ONES, 1'b0, 1'b0, r);
      chk("t3a_s", val_t'(r.s), val_t'(NEG2));
      chk("t3a_co", val_t'(r.co), val_t'(1));
      chk("t3a_ovf", val_t'(r.ovf), val_t'(0));
      chk("t3a_g", val_t'(r.g), val_t'(1));

      one_beat(ONES, '0, 1'b1, 1'b0, r);
      chk("t3b_s", val_t'(r.s), val_t'(0));
      chk("t3b_co", val_t'(r.co), val_t'(1));
      chk("t3b_p", val_t'(r.p), val_t'(1));
      chk("t3b_c", val_t'(r.c), val_t'(ONES));

      one_beat(WIDTH'(5), WIDTH'(7), 1'b1, 1'b1, r);
      chk("t4a_s", val_t'(r.s), val_t'(NEG2));
      chk("t4a_co", val_t'(r.co), val_t'(0));

      one_beat(MSB, WIDTH'(1), 1'b0, 1'b1, r);
      chk("t4b_s", val_t'(r.s), val_t'(MAXPOS));
      chk("t4b_ovf", val_t'(r.ovf), val_t'(1));
      chk("t4b_co", val_t'(r.co), val_t'(1));

      // Stream of 8 beats with the consumer stalling for cycles 3-5.
      sent = 0;
      held = 1'b0;
      rand_operands();
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_valid  = (sent < 8);
         out_ready = !(cyc >= 3 && cyc <= 5);
         step(acc);
         if (acc) begin
            sent++;
            rand_operands();
         end
      end
      chk("t5_sent", val_t'(sent), val_t'(8));
      chk("t5_left", val_t'(q.size()), val_t'(0));

      // Reset while beats are in flight: nothing may emerge afterwards.
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid  = 1'b1;
         out_ready = (cyc != 4);
         rand_operands();
         step(acc);
      end
      rst = 1'b1;
      #1;
      chk("t1_valid", val_t'(out_valid), val_t'(0));
      chk("t1_s", val_t'(s), val_t'(0));
      chk("t1_co", val_t'(co), val_t'(0));
      q.delete();
      held = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < STAGES + 3; cyc++) begin
         #1 chk("t1_stale", val_t'(out_valid), val_t'(0));
         step(acc);
      end

      // Long random run with random producer/consumer pressure.
      rand_operands();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step(acc);
         if (acc) rand_operands();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 4 * STAGES + 8 && q.size() > 0; cyc++) step(acc);
      chk("t6_left", val_t'(q.size()), val_t'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
